// File: rtl/blink_scheduler.sv
// Round-robin burst scheduler: two requesters share one prescaler and take
// turns running bursts of LED toggles at their own half-period.
module blink_scheduler #(
    parameter int CNT_WIDTH   = 24,
    parameter int BURST_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [CNT_WIDTH-1:0]   period0,
    input  logic [CNT_WIDTH-1:0]   period1,
    input  logic [BURST_WIDTH-1:0] count0,
    input  logic [BURST_WIDTH-1:0] count1,
    input  logic                   abort,
    output logic [1:0]             ack,
    output logic [1:0]             done,
    output logic                   aborted,
    output logic                   busy,
    output logic [1:0]             led
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   id;
    logic                   last;
    logic [CNT_WIDTH-1:0]   presc;
    logic [CNT_WIDTH-1:0]   period_l;
    logic [BURST_WIDTH-1:0] remaining;

    logic can_grant, prefer_last, gid, tick, finish;

    always_comb begin
        can_grant   = (state == IDLE || state == DONE) && (req != 2'b00);
        // Leaving DONE, the pointer update to id is not yet visible in last.
        prefer_last = (state == DONE) ? id : last;
        case (req)
            2'b01:   gid = 1'b0;
            2'b10:   gid = 1'b1;
            default: gid = ~prefer_last;
        endcase
        tick   = (presc == period_l);
        // A zero-count burst still spends one RUN cycle so done lands after ack.
        finish = (state == RUN) &&
                 (abort || remaining == '0 || (tick && remaining == BURST_WIDTH'(1)));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_grant) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DONE;
            DONE:    state_nxt = can_grant ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id        <= 1'b0;
            last      <= 1'b1;
            presc     <= '0;
            period_l  <= '0;
            remaining <= '0;
            led       <= 2'b00;
            ack       <= 2'b00;
            done      <= 2'b00;
            aborted   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ack     <= 2'b00;
            done    <= 2'b00;
            aborted <= 1'b0;
            case (state)
                RUN: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick && remaining != '0) begin
                        led[id]   <= ~led[id];
                        remaining <= remaining - 1'b1;
                    end
                    if (finish) begin
                        done[id] <= 1'b1;
                        aborted  <= abort;
                    end
                end
                default: begin
                    if (state == DONE) last <= id;
                    if (can_grant) begin
                        id        <= gid;
                        period_l  <= gid ? period1 : period0;
                        remaining <= gid ? count1 : count0;
                        presc     <= '0;
                        ack[gid]  <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler: reset, single burst timing, round-robin,
// zero-count, abort and mid-burst reset.
module tb_blink_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [23:0] period0, period1;
    logic [3:0]  count0, count1;
    logic        abort;
    logic [1:0]  ack, done, led;
    logic        aborted, busy;

    int tests = 0;
    int fails = 0;

    blink_scheduler #(.CNT_WIDTH(24), .BURST_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .period0(period0), .period1(period1),
        .count0(count0), .count1(count1), .abort(abort),
        .ack(ack), .done(done), .aborted(aborted), .busy(busy), .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b11; abort = 1'b0;
        period0 = 24'd0; period1 = 24'd0; count0 = 4'd2; count1 = 4'd1;
        repeat (3) @(negedge clk);
        chk("rst_led", led, 2'b00);
        chk("rst_ack", ack, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_aborted", aborted, 1'b0);

        // First grant after reset goes to requester 0; count 2 leaves led0 at 0.
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr0_ack", ack, 2'b01);
        chk("rr0_busy", busy, 1'b1);
        req = 2'b00;
        @(negedge clk);
        chk("b0_led_t1", led, 2'b01);
        @(negedge clk);
        chk("b0_done", done, 2'b01);
        chk("b0_led_end", led, 2'b00);
        @(negedge clk);
        chk("b0_idle_busy", busy, 1'b0);

        // Single burst: period 2, count 4 -> toggles at t+3,6,9,12.
        period0 = 24'd2; count0 = 4'd4; req = 2'b01;
        @(negedge clk);
        chk("sb_ack", ack, 2'b01);
        req = 2'b00;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk("sb_led", led, {1'b0, (k > 12 ? 1'b0 : 1'((k / 3) % 2))});
            chk("sb_done", done, (k == 12) ? 2'b01 : 2'b00);
            chk("sb_busy", busy, (k <= 12) ? 1'b1 : 1'b0);
        end

        // Reset pulse so round-robin starts preferring requester 0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        period0 = 24'd0; period1 = 24'd0; count0 = 4'd1; count1 = 4'd1;
        req = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("rr_ack", ack, ((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
                chk("rr_done", done, 2'b00);
            end else begin
                chk("rr_ack", ack, 2'b00);
                chk("rr_done", done, ((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        req = 2'b00;
        @(negedge clk);
        chk("rr_led", led, 2'b00);
        chk("rr_busy", busy, 1'b0);

        // Zero count: ack then done next cycle, no toggle.
        count1 = 4'd0; req = 2'b10;
        @(negedge clk);
        chk("z_ack", ack, 2'b10);
        chk("z_done0", done, 2'b00);
        req = 2'b00;
        @(negedge clk);
        chk("z_done", done, 2'b10);
        chk("z_ack_lo", ack, 2'b00);
        chk("z_aborted", aborted, 1'b0);
        chk("z_led", led, 2'b00);
        @(negedge clk);

        // Abort after second toggle (period 9 -> toggles at t+10, t+20).
        period0 = 24'd9; count0 = 4'd6; req = 2'b01;
        @(negedge clk);
        chk("ab_ack", ack, 2'b01);
        req = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 10) chk("ab_led_t1", led, 2'b01);
        end
        chk("ab_led_t2", led, 2'b00);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_done", done, 2'b01);
        chk("ab_aborted", aborted, 1'b1);
        chk("ab_led", led, 2'b00);
        @(negedge clk);
        chk("ab_aborted_lo", aborted, 1'b0);
        chk("ab_busy", busy, 1'b0);

        // Reset mid-burst with led1 high, then a fresh burst runs full count.
        period1 = 24'd9; count1 = 4'd4; req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        repeat (12) @(negedge clk);
        chk("mr_led_pre", led, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("mr_led", led, 2'b00);
        chk("mr_busy", busy, 1'b0);
        chk("mr_done", done, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        period1 = 24'd1; req = 2'b10;
        @(negedge clk);
        chk("mr_ack", ack, 2'b10);
        req = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 7) chk("mr_done_early", done, 2'b00);
            if (k == 8) begin
                chk("mr_done_full", done, 2'b10);
                chk("mr_led_end", led, 2'b00);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
